adc_conv_arbiter: RTL
=====================

# adc_conv_arbiter

Round-robin arbiter and sequencer that shares the single SPI ADC conversion engine among several on-board clients (line-sensor scan, colour-sensor RGB channels 5/6/7, battery monitor). Each client requests one 12-bit conversion on a chosen channel. The arbiter grants one client at a time and issues a start pulse to the conversion engine. It returns the result with a one-cycle acknowledge, and recovers from a hung engine via a watchdog. Sits between the client FSMs and the ADC SPI engine, all in the 50 MHz domain.

## Interface
- N_REQ, 4, number of requesting clients (2..8)
- CH_W, 3, ADC channel select width
- DATA_W, 12, conversion result width
- TIMEOUT, 1023, max cycles waited for adc_done before error (one SPI frame = 320 cycles)

- clk_50  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-client request level; held until matching ack
- req_ch  in  N_REQ*CH_W  client i channel in bits [i*CH_W +: CH_W]
- ack  out  N_REQ  one-cycle pulse to the granted client; rsp_* valid this cycle
- rsp_data  out  DATA_W  conversion result; held until next RESP
- rsp_err  out  1  valid with ack; 1 = watchdog expired, rsp_data forced to 0
- adc_start  out  1  one-cycle start pulse to the conversion engine
- adc_ch  out  CH_W  channel for the engine; stable from ISSUE until the next grant
- adc_done  in  1  one-cycle pulse from the engine, result valid
- adc_data  in  DATA_W  engine result, sampled only on adc_done
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if req != 0, pick the winner by round robin. Search starts at last_grant+1 and wraps modulo N_REQ. Latch the winner index and its req_ch into adc_ch. Go to ISSUE. If req == 0, stay.
- ISSUE: adc_start=1 for exactly one cycle. Clear the watchdog counter. Go to WAIT.
- WAIT: the watchdog increments each cycle.
  - On adc_done: capture adc_data into rsp_data, set rsp_err=0, go to RESP.
  - If the counter reaches TIMEOUT-1 with no adc_done: set rsp_data=0, rsp_err=1, go to RESP.
  - If adc_done arrives on the same cycle as the timeout, adc_done wins and rsp_err=0.
- RESP: ack[winner]=1 for one cycle. Set last_grant=winner. Go to IDLE.
- adc_done outside WAIT is ignored, with no state or data change.
- A client dropping req before its ack does not abort the transaction. The ack is still pulsed and the client ignores it.
- A client's channel is sampled only at grant. Later req_ch changes have no effect on the transaction in flight.
- Reset values: state=IDLE, ack=0, rsp_data=0, rsp_err=0, adc_start=0, adc_ch=0, busy=0, watchdog=0.
  - last_grant resets to N_REQ-1, so client 0 has first priority after reset.
  - Reset mid-transaction returns to IDLE immediately and issues no ack. A late adc_done from the engine is ignored.
- All outputs are registered. No combinational path from inputs to outputs.

## Timing
- req rising at edge n while IDLE: adc_start=1 in cycle n+1 (ISSUE) and busy rises in n+1.
- adc_done in cycle m: ack and rsp_data valid in cycle m+1.
- Back-to-back: after RESP, one IDLE cycle, then the next ISSUE. Minimum per-transaction overhead is 3 cycles plus engine latency.
- Timeout transaction: ack at ISSUE+TIMEOUT+1 cycles.
- Fairness: with all N_REQ requesting continuously, each client is granted exactly once every N_REQ transactions.

## Structure
- Package adc_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - default CH_W/DATA_W constants;
  - colour channel constants CH_RED=5, CH_GREEN=6, CH_BLUE=7.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req[N_REQ], last_grant index. Outputs: winner index, any_valid.
  - Uses a rotate, priority-encode and un-rotate scheme.
- Top holds the FSM, watchdog counter and output registers. Top is about 150–250 lines.

## Test plan
- Single client: req[2]=1, req_ch[2]=6. Engine model answers adc_done 320 cycles after adc_start with 1998 → adc_ch=6, one adc_start pulse, ack=4'b0100 for one cycle, rsp_data=1998, rsp_err=0.
- All four requesting continuously after reset, channels 4,5,6,7, engine returns 100+ch → acks in order client 0,1,2,3,0,… with rsp_data 104,105,106,107. Exactly one adc_start per ack.
- Watchdog: grant client 1 with the engine silent → ack[1] exactly 1024 cycles after adc_start, rsp_err=1, rsp_data=0. The next request is then served normally.
- Collision and spurious pulses:
  - adc_done on the exact timeout cycle → rsp_err=0 with captured data.
  - adc_done pulsed while IDLE → no ack, state unchanged.
- Reset mid-WAIT: assert rst 50 cycles after adc_start → all outputs 0 at once. A later adc_done is ignored and no ack is issued. After release, client 0 wins over client 3 when both request.
- Stability: change req_ch[0] from 5 to 7 during WAIT, and drop req[0] before done → adc_ch stays 5 and ack[0] is still pulsed.

Source files
------------

// File: rtl/adc_arb_pkg.sv
// adc_arb_pkg: shared types and constants for the ADC conversion arbiter.
//   state_t          arbiter FSM encoding (IDLE, ISSUE, WAIT, RESP)
//   DEF_CH_W/DATA_W  default channel-select and result widths
//   CH_RED/GREEN/BLUE colour-sensor ADC channels
package adc_arb_pkg;

  localparam int unsigned DEF_CH_W   = 3;
  localparam int unsigned DEF_DATA_W = 12;

  localparam logic [DEF_CH_W-1:0] CH_RED   = 3'd5;
  localparam logic [DEF_CH_W-1:0] CH_GREEN = 3'd6;
  localparam logic [DEF_CH_W-1:0] CH_BLUE  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/adc_conv_arbiter_if.sv
// adc_conv_arbiter_if: link between the arbiter and the SPI ADC conversion engine.
//   adc_start  one-cycle conversion start pulse (arbiter -> engine)
//   adc_ch     channel to convert (arbiter -> engine)
//   adc_done   one-cycle result-valid pulse (engine -> arbiter)
//   adc_data   conversion result, valid with adc_done (engine -> arbiter)
// master = arbiter side, slave = engine side.
interface adc_conv_arbiter_if
  import adc_arb_pkg::*;
#(
  parameter int unsigned CH_W   = DEF_CH_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              adc_start;
  logic [CH_W-1:0]   adc_ch;
  logic              adc_done;
  logic [DATA_W-1:0] adc_data;

  modport master (output adc_start, output adc_ch, input adc_done, input adc_data);
  modport slave  (input adc_start, input adc_ch, output adc_done, output adc_data);

endinterface

// File: rtl/adc_conv_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req         per-client request vector
//   last_grant  index of the most recently served client
//   winner      first requesting client searching from last_grant+1, wrapping
//   any_valid   at least one request present
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  logic [N_REQ-1:0] rot;
  int unsigned      base;
  int unsigned      off;
  logic             found;

  // Rotate so the search origin sits at bit 0, take the lowest set bit,
  // then add the origin back to recover the absolute client index.
  always_comb begin
    base = (32'(last_grant) + 1) % N_REQ;
    rot  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rot[IDX_W'(i)] = req[IDX_W'((base + i) % N_REQ)];
    end
    found = 1'b0;
    off   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && rot[IDX_W'(i)]) begin
        found = 1'b1;
        off   = i;
      end
    end
    winner    = IDX_W'((base + off) % N_REQ);
    any_valid = |req;
  end

endmodule

// File: rtl/adc_conv_arbiter.sv
// adc_conv_arbiter: round-robin sharing of one SPI ADC conversion engine.
//   clk_50    50 MHz system clock
//   rst       asynchronous active-high reset
//   req       per-client request level, held until ack
//   req_ch    client i channel in bits [i*CH_W +: CH_W], sampled at grant
//   ack       one-cycle pulse to the served client; rsp_* valid with it
//   rsp_data  conversion result (0 on watchdog expiry), held until next ack
//   rsp_err   1 = engine did not answer within TIMEOUT cycles
//   busy      high in every state except IDLE
//   adc       engine link (master side): adc_start/adc_ch out, adc_done/adc_data in
module adc_conv_arbiter
  import adc_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned CH_W    = DEF_CH_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                    clk_50,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*CH_W-1:0]   req_ch,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  adc_conv_arbiter_if.master      adc
);

  localparam int unsigned      IDX_W    = $clog2(N_REQ);
  localparam int unsigned      WD_W     = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  state_t           state;
  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] last_grant;
  logic [WD_W-1:0]  wdog;
  logic [CH_W-1:0]  pick_ch;
  logic [N_REQ-1:0] grant_vec;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .winner     (pick),
    .any_valid  (any_req)
  );

  always_comb begin
    pick_ch = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick == IDX_W'(i)) pick_ch = req_ch[i*CH_W +: CH_W];
    end
  end

  always_comb begin
    grant_vec = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      grant_vec[IDX_W'(i)] = (winner == IDX_W'(i));
    end
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      winner        <= '0;
      last_grant    <= LAST_RST;
      wdog          <= '0;
      ack           <= '0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      busy          <= 1'b0;
      adc.adc_start <= 1'b0;
      adc.adc_ch    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            winner        <= pick;
            adc.adc_ch    <= pick_ch;
            adc.adc_start <= 1'b1;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          adc.adc_start <= 1'b0;
          wdog          <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          // adc_done is tested first so a result landing on the expiry
          // cycle is still delivered as a good conversion.
          if (adc.adc_done) begin
            rsp_data <= adc.adc_data;
            rsp_err  <= 1'b0;
            ack      <= grant_vec;
            state    <= RESP;
          end else if (wdog == WD_LAST) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            ack      <= grant_vec;
            state    <= RESP;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        RESP: begin
          ack        <= '0;
          last_grant <= winner;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
